// File: rtl/mips_cpu_regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Arbitrates ALU / MEM / LINK, registers the winner, tracks pending loads.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   alu_valid/ready/reg/data   ALU writeback request
//   mem_valid/ready/reg/data   load writeback request
//   mem_orwrite/shiftdata/loadlr  LWL/LWR merge controls
//   link_valid/ready/data      JAL/JALR return address (dest 31)
//   pend_valid/pend_reg        load issued, mark destination pending
//   query_reg_1/2, hazard      decode RAW check against pending loads
//   write_enable/reg/data, orwrite, shiftdata, loadlorloadr
//                              registered register-file write port
module mips_cpu_regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    input  logic        mem_orwrite,
    input  logic [1:0]  mem_shiftdata,
    input  logic        mem_loadlr,
    input  logic        link_valid,
    output logic        link_ready,
    input  logic [31:0] link_data,
    input  logic        pend_valid,
    input  logic [4:0]  pend_reg,
    input  logic [4:0]  query_reg_1,
    input  logic [4:0]  query_reg_2,
    output logic        hazard,
    output logic        write_enable,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        orwrite,
    output logic [1:0]  shiftdata,
    output logic        loadlorloadr
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]  starve_q, starve_d;
    logic [31:0] sb_q, sb_d;
    logic        we_q, we_d;
    logic        memwr_q, memwr_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic        or_q, or_d;
    logic [1:0]  sh_q, sh_d;
    logic        lr_q, lr_d;
    logic        promote;

    // A starved ALU jumps ahead of everything for one grant.
    assign promote    = alu_valid && (starve_q == LIMIT);
    assign alu_ready  = alu_valid && (promote || (!mem_valid && !link_valid));
    assign mem_ready  = mem_valid && !promote;
    assign link_ready = link_valid && !mem_valid && !promote;

    always_comb begin
        we_d    = 1'b0;
        memwr_d = 1'b0;
        wreg_d  = 5'd0;
        wdata_d = 32'd0;
        or_d    = 1'b0;
        sh_d    = 2'd0;
        lr_d    = 1'b0;
        unique case (1'b1)
            mem_ready: begin
                we_d    = (mem_reg != 5'd0);
                memwr_d = (mem_reg != 5'd0);
                wreg_d  = mem_reg;
                wdata_d = mem_data;
                or_d    = mem_orwrite;
                sh_d    = mem_shiftdata;
                lr_d    = mem_loadlr;
            end
            link_ready: begin
                we_d    = 1'b1;
                wreg_d  = 5'd31;
                wdata_d = link_data;
            end
            alu_ready: begin
                we_d    = (alu_reg != 5'd0);
                wreg_d  = alu_reg;
                wdata_d = alu_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!alu_valid || alu_ready) begin
            starve_d = 8'd0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 8'd1;
        end
    end

    // Clear first, then set: a younger load to the same register wins.
    always_comb begin
        sb_d = sb_q;
        if (we_q && memwr_q) begin
            sb_d[wreg_q] = 1'b0;
        end
        if (pend_valid) begin
            sb_d[pend_reg] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= 8'd0;
            sb_q     <= 32'd0;
            we_q     <= 1'b0;
            memwr_q  <= 1'b0;
            wreg_q   <= 5'd0;
            wdata_q  <= 32'd0;
            or_q     <= 1'b0;
            sh_q     <= 2'd0;
            lr_q     <= 1'b0;
        end else begin
            starve_q <= starve_d;
            sb_q     <= sb_d;
            we_q     <= we_d;
            memwr_q  <= memwr_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            or_q     <= or_d;
            sh_q     <= sh_d;
            lr_q     <= lr_d;
        end
    end

    assign hazard = (sb_q[query_reg_1] && (query_reg_1 != 5'd0)) ||
                    (sb_q[query_reg_2] && (query_reg_2 != 5'd0));

    assign write_enable = we_q;
    assign write_reg    = wreg_q;
    assign write_data   = wdata_q;
    assign orwrite      = or_q;
    assign shiftdata    = sh_q;
    assign loadlorloadr = lr_q;

endmodule

// File: tb/tb_mips_cpu_regfile_wb_arbiter.sv
// Testbench for mips_cpu_regfile_wb_arbiter.
// Table of per-cycle vectors plus starvation and reset sequences.
module tb_mips_cpu_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        mem_orwrite;
    logic [1:0]  mem_shiftdata;
    logic        mem_loadlr;
    logic        link_valid, link_ready;
    logic [31:0] link_data;
    logic        pend_valid;
    logic [4:0]  pend_reg;
    logic [4:0]  query_reg_1, query_reg_2;
    logic        hazard;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        orwrite;
    logic [1:0]  shiftdata;
    logic        loadlorloadr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_cpu_regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_reg(mem_reg), .mem_data(mem_data),
        .mem_orwrite(mem_orwrite), .mem_shiftdata(mem_shiftdata),
        .mem_loadlr(mem_loadlr),
        .link_valid(link_valid), .link_ready(link_ready),
        .link_data(link_data),
        .pend_valid(pend_valid), .pend_reg(pend_reg),
        .query_reg_1(query_reg_1), .query_reg_2(query_reg_2),
        .hazard(hazard),
        .write_enable(write_enable), .write_reg(write_reg),
        .write_data(write_data), .orwrite(orwrite),
        .shiftdata(shiftdata), .loadlorloadr(loadlorloadr)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        mo;
        logic [1:0]  ms;
        logic        ml;
        logic        lv;
        logic [31:0] ld;
        logic        pv;
        logic [4:0]  pr;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic [2:0]  erdy;
        logic        ehz;
        logic        ewe;
        logic [4:0]  ereg;
        logic [31:0] edat;
        logic        eor;
        logic [1:0]  esh;
        logic        elr;
    } vec_t;

    vec_t tbl[$];
    vec_t cur;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic nv();
        cur = '{default: '0};
    endtask

    task automatic a(input logic [4:0] r, input logic [31:0] d);
        cur.av = 1'b1; cur.ar = r; cur.ad = d;
    endtask

    task automatic m(input logic [4:0] r, input logic [31:0] d,
                     input logic o, input logic [1:0] s, input logic l);
        cur.mv = 1'b1; cur.mr = r; cur.md = d;
        cur.mo = o; cur.ms = s; cur.ml = l;
    endtask

    task automatic lk(input logic [31:0] d);
        cur.lv = 1'b1; cur.ld = d;
    endtask

    task automatic pq(input logic pv, input logic [4:0] pr,
                      input logic [4:0] q1, input logic [4:0] q2);
        cur.pv = pv; cur.pr = pr; cur.q1 = q1; cur.q2 = q2;
    endtask

    task automatic e(input logic [2:0] rdy, input logic hz,
                     input logic we, input logic [4:0] r,
                     input logic [31:0] d, input logic o,
                     input logic [1:0] s, input logic l);
        cur.erdy = rdy; cur.ehz = hz; cur.ewe = we; cur.ereg = r;
        cur.edat = d; cur.eor = o; cur.esh = s; cur.elr = l;
        tbl.push_back(cur);
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        mem_orwrite = 1'b0; mem_shiftdata = '0; mem_loadlr = 1'b0;
        link_valid = 1'b0; link_data = '0;
        pend_valid = 1'b0; pend_reg = '0;
        query_reg_1 = '0; query_reg_2 = '0;
    endtask

    // One cycle: drive, check combinational outputs, clock, check port.
    task automatic run_vec(input vec_t v, input int idx);
        reset = v.rst;
        alu_valid = v.av; alu_reg = v.ar; alu_data = v.ad;
        mem_valid = v.mv; mem_reg = v.mr; mem_data = v.md;
        mem_orwrite = v.mo; mem_shiftdata = v.ms; mem_loadlr = v.ml;
        link_valid = v.lv; link_data = v.ld;
        pend_valid = v.pv; pend_reg = v.pr;
        query_reg_1 = v.q1; query_reg_2 = v.q2;
        #1;
        chk($sformatf("v%0d ready{alu,mem,link}", idx),
            32'({alu_ready, mem_ready, link_ready}), 32'(v.erdy));
        chk($sformatf("v%0d hazard", idx), 32'(hazard), 32'(v.ehz));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d write_enable", idx),
            32'(write_enable), 32'(v.ewe));
        if (v.ewe) begin
            chk($sformatf("v%0d write_reg", idx),
                32'(write_reg), 32'(v.ereg));
            chk($sformatf("v%0d write_data", idx), write_data, v.edat);
            chk($sformatf("v%0d orwrite", idx), 32'(orwrite), 32'(v.eor));
            chk($sformatf("v%0d shiftdata", idx),
                32'(shiftdata), 32'(v.esh));
            chk($sformatf("v%0d loadlorloadr", idx),
                32'(loadlorloadr), 32'(v.elr));
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("reset write_enable", 32'(write_enable), 32'd0);
        chk("reset write_reg", 32'(write_reg), 32'd0);
        chk("reset write_data", write_data, 32'd0);
        chk("reset hazard", 32'(hazard), 32'd0);
        chk("reset readies", 32'({alu_ready, mem_ready, link_ready}),
            32'd0);

        // ALU only
        nv(); a(5, 32'h1234);
        e(3'b100, 0, 1, 5, 32'h1234, 0, 0, 0);
        nv(); e(3'b000, 0, 0, 0, 0, 0, 0, 0);
        // All three: MEM, then LINK, then ALU
        nv(); a(3, 32'hA); m(4, 32'hB, 0, 0, 0); lk(32'hC);
        e(3'b010, 0, 1, 4, 32'hB, 0, 0, 0);
        nv(); a(3, 32'hA); lk(32'hC);
        e(3'b001, 0, 1, 31, 32'hC, 0, 0, 0);
        nv(); a(3, 32'hA);
        e(3'b100, 0, 1, 3, 32'hA, 0, 0, 0);
        // LWR merge, then writes to reg 0
        nv(); m(9, 32'h55667788, 1, 2, 1);
        e(3'b010, 0, 1, 9, 32'h55667788, 1, 2, 1);
        nv(); a(0, 32'hFFFF);
        e(3'b100, 0, 0, 0, 0, 0, 0, 0);
        nv(); m(0, 32'h1, 0, 0, 0);
        e(3'b010, 0, 0, 0, 0, 0, 0, 0);
        nv(); lk(32'h400);
        e(3'b001, 0, 1, 31, 32'h400, 0, 0, 0);
        // Scoreboard on reg 8
        nv(); pq(1, 8, 8, 0);
        e(3'b000, 0, 0, 0, 0, 0, 0, 0);
        nv(); pq(0, 0, 8, 0);
        e(3'b000, 1, 0, 0, 0, 0, 0, 0);
        nv(); pq(0, 0, 3, 8); m(8, 32'h88, 0, 0, 0);
        e(3'b010, 1, 1, 8, 32'h88, 0, 0, 0);
        nv(); pq(1, 8, 8, 0);
        e(3'b000, 1, 0, 0, 0, 0, 0, 0);
        nv(); pq(0, 0, 8, 0); m(8, 32'h99, 0, 0, 0);
        e(3'b010, 1, 1, 8, 32'h99, 0, 0, 0);
        nv(); pq(0, 0, 8, 0);
        e(3'b000, 1, 0, 0, 0, 0, 0, 0);
        nv(); pq(1, 0, 8, 0);
        e(3'b000, 0, 0, 0, 0, 0, 0, 0);
        nv(); pq(1, 7, 0, 0);
        e(3'b000, 0, 0, 0, 0, 0, 0, 0);
        // ALU write does not clear a pending load
        nv(); pq(0, 0, 7, 0); a(7, 32'h7);
        e(3'b100, 1, 1, 7, 32'h7, 0, 0, 0);
        nv(); pq(0, 0, 0, 7); m(7, 32'h70, 0, 0, 0);
        e(3'b010, 1, 1, 7, 32'h70, 0, 0, 0);
        nv(); pq(0, 0, 7, 7);
        e(3'b000, 1, 0, 0, 0, 0, 0, 0);
        nv(); pq(0, 0, 7, 7);
        e(3'b000, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], i);
        end

        // Starvation: MEM valid 10 cycles with ALU always valid
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            logic exp_alu;
            exp_alu = (i == 4) || (i == 9);
            alu_valid = 1'b1; alu_reg = 5'd2; alu_data = 32'h200 + i;
            mem_valid = 1'b1; mem_reg = 5'd6; mem_data = 32'h600 + i;
            #1;
            chk($sformatf("starve c%0d alu_ready", i),
                32'(alu_ready), 32'(exp_alu));
            chk($sformatf("starve c%0d mem_ready", i),
                32'(mem_ready), 32'(!exp_alu));
            @(posedge clk); #1;
            chk($sformatf("starve c%0d write_reg", i),
                32'(write_reg), exp_alu ? 32'd2 : 32'd6);
            chk($sformatf("starve c%0d write_data", i), write_data,
                exp_alu ? 32'h200 + i : 32'h600 + i);
        end

        // Reset while a grant is in flight
        idle_inputs();
        pend_valid = 1'b1; pend_reg = 5'd8;
        @(posedge clk); #1;
        idle_inputs();
        query_reg_1 = 5'd8;
        mem_valid = 1'b1; mem_reg = 5'd8; mem_data = 32'hDEAD;
        reset = 1'b1;
        #1;
        chk("pre-reset hazard", 32'(hazard), 32'd1);
        @(posedge clk); #1;
        chk("reset in flight write_enable", 32'(write_enable), 32'd0);
        chk("reset in flight hazard", 32'(hazard), 32'd0);
        idle_inputs();
        query_reg_1 = 5'd8;
        @(posedge clk); #1;
        chk("post-reset write_enable", 32'(write_enable), 32'd0);
        chk("post-reset hazard", 32'(hazard), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
